// File: rtl/posit_mac_pkg.sv
// Shared definitions for the posit MAC datapath: sequencer states, widths and
// the precision legality rule used by the configuration path.
package posit_mac_pkg;

    localparam int PREC_W        = 4;
    localparam int RES_MAN_EXTRA = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

    // A posit needs at least a sign and one regime bit, and must fit the weight bus.
    function automatic logic prec_legal(input logic [PREC_W-1:0] p, input int w_max);
        return (int'(p) >= 2) && (int'(p) <= w_max);
    endfunction

endpackage

// File: rtl/posit_mul_seq_if.sv
// Bundle of config, operand, result and multiplier-side signals of posit_mul_seq.
// slave is the sequencer's view; master is the surrounding system's view.
interface posit_mul_seq_if #(
    parameter int ACT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int W_MAX     = 8
);
    import posit_mac_pkg::*;

    logic                   cfg_valid;
    logic [PREC_W-1:0]      cfg_precision;
    logic                   cfg_err;

    logic                   in_valid;
    logic                   in_ready;
    logic [ACT_WIDTH-1:0]   in_act;
    logic [W_MAX-1:0]       in_w;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sign;
    logic [EXP_WIDTH-1:0]   out_exp;
    logic [MAN_WIDTH+3:0]   out_man;
    logic                   out_zero;
    logic                   out_nar;
    logic                   out_timeout;

    logic [ACT_WIDTH-1:0]   mul_act;
    logic                   mul_w;
    logic                   mul_valid;
    logic                   mul_set;
    logic [PREC_W-1:0]      mul_precision;
    logic                   mul_sign;
    logic [EXP_WIDTH-1:0]   mul_exp;
    logic [MAN_WIDTH+3:0]   mul_man;
    logic                   mul_zero;
    logic                   mul_nar;
    logic                   mul_done;

    modport slave (
        input  cfg_valid, cfg_precision, in_valid, in_act, in_w, out_ready,
               mul_sign, mul_exp, mul_man, mul_zero, mul_nar, mul_done,
        output cfg_err, in_ready, out_valid, out_sign, out_exp, out_man,
               out_zero, out_nar, out_timeout,
               mul_act, mul_w, mul_valid, mul_set, mul_precision
    );

    modport master (
        output cfg_valid, cfg_precision, in_valid, in_act, in_w, out_ready,
               mul_sign, mul_exp, mul_man, mul_zero, mul_nar, mul_done,
        input  cfg_err, in_ready, out_valid, out_sign, out_exp, out_man,
               out_zero, out_nar, out_timeout,
               mul_act, mul_w, mul_valid, mul_set, mul_precision
    );

endinterface

// File: rtl/posit_w_serializer.sv
// Loads a right-aligned posit weight, left-justifies it on the active precision
// and shifts it out MSB-first while counting the remaining bits.
module posit_w_serializer
    import posit_mac_pkg::*;
#(
    parameter int W_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [W_MAX-1:0]  w_in,
    input  logic [PREC_W-1:0] prec,
    output logic              ser_bit,
    output logic              last
);

    logic [W_MAX-1:0]  sreg_reg;
    logic [W_MAX-1:0]  aligned;
    logic [W_MAX-1:0]  shifted;
    logic [PREC_W-1:0] cnt_reg;

    // Shifting left by W_MAX-prec drops the unused upper bits and puts bit prec-1 at the MSB.
    assign aligned = w_in << (PREC_W'(W_MAX) - prec);

    generate
        for (genvar gi = 0; gi < W_MAX; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = 1'b0;
            end else begin : g_up
                assign shifted[gi] = sreg_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            sreg_reg <= aligned;
            cnt_reg  <= prec;
        end else if (shift) begin
            sreg_reg <= shifted;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - PREC_W'(1);
            end
        end
    end

    assign ser_bit = sreg_reg[W_MAX-1];
    assign last    = (cnt_reg == PREC_W'(1));

endmodule

// File: rtl/posit_mul_seq.sv
// Sequencer for the bit-serial FP16 x posit multiplier: programs precision,
// serializes weights, captures results (or a timeout NaR) with backpressure.
module posit_mul_seq
    import posit_mac_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int W_MAX     = 8,
    parameter int PREC_RST  = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic              clk,
    input  logic              rst,
    posit_mul_seq_if.slave    bus
);

    localparam int RES_MAN_W = MAN_WIDTH + RES_MAN_EXTRA;
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    seq_state_t            state_reg;
    seq_state_t            state_next;
    logic [PREC_W-1:0]     prec_reg;
    logic [ACT_WIDTH-1:0]  act_reg;
    logic [TO_W-1:0]       to_cnt_reg;
    logic                  cfg_err_reg;
    logic                  out_valid_reg;
    logic                  out_sign_reg;
    logic [EXP_WIDTH-1:0]  out_exp_reg;
    logic [RES_MAN_W-1:0]  out_man_reg;
    logic                  out_zero_reg;
    logic                  out_nar_reg;
    logic                  out_timeout_reg;

    logic in_ready_c, mul_valid_c, mul_set_c, mul_w_c;
    logic cfg_ok, cfg_bad, accept, capture_done, capture_to;
    logic ser_bit, ser_last;

    assign cfg_ok       = (state_reg == ST_IDLE) && bus.cfg_valid &&  prec_legal(bus.cfg_precision, W_MAX);
    assign cfg_bad      = (state_reg == ST_IDLE) && bus.cfg_valid && !prec_legal(bus.cfg_precision, W_MAX);
    assign accept       = bus.in_valid && in_ready_c;
    assign capture_done = bus.mul_done && ((state_reg == ST_SHIFT) || (state_reg == ST_WAIT));
    assign capture_to   = (state_reg == ST_WAIT) && !bus.mul_done && (to_cnt_reg == TO_W'(TIMEOUT - 1));

    posit_w_serializer #(.W_MAX(W_MAX)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (state_reg == ST_SHIFT),
        .w_in    (bus.in_w),
        .prec    (prec_reg),
        .ser_bit (ser_bit),
        .last    (ser_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cfg_ok) state_next = ST_CFG;
                      else if (accept) state_next = ST_SHIFT;
            ST_CFG:   state_next = ST_IDLE;
            ST_SHIFT: if (bus.mul_done) state_next = ST_IDLE;
                      else if (ser_last) state_next = ST_WAIT;
            ST_WAIT:  if (capture_done || capture_to) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Accepting only when the result slot is free or draining guarantees no capture is ever dropped.
    always_comb begin
        in_ready_c  = (state_reg == ST_IDLE) && !bus.cfg_valid && (!out_valid_reg || bus.out_ready);
        mul_valid_c = (state_reg == ST_SHIFT);
        mul_set_c   = (state_reg == ST_CFG);
        mul_w_c     = (state_reg == ST_SHIFT) && ser_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prec_reg        <= PREC_W'(PREC_RST);
            act_reg         <= '0;
            to_cnt_reg      <= '0;
            cfg_err_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_sign_reg    <= 1'b0;
            out_exp_reg     <= '0;
            out_man_reg     <= '0;
            out_zero_reg    <= 1'b0;
            out_nar_reg     <= 1'b0;
            out_timeout_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_bad;
            if (cfg_ok) begin
                prec_reg <= bus.cfg_precision;
            end
            if (accept) begin
                act_reg <= bus.in_act;
            end
            if (state_reg == ST_WAIT) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end else begin
                to_cnt_reg <= '0;
            end
            if (capture_done) begin
                out_valid_reg   <= 1'b1;
                out_sign_reg    <= bus.mul_sign;
                out_exp_reg     <= bus.mul_exp;
                out_man_reg     <= bus.mul_man;
                out_zero_reg    <= bus.mul_zero;
                out_nar_reg     <= bus.mul_nar;
                out_timeout_reg <= 1'b0;
            end else if (capture_to) begin
                out_valid_reg   <= 1'b1;
                out_sign_reg    <= 1'b0;
                out_exp_reg     <= '0;
                out_man_reg     <= '0;
                out_zero_reg    <= 1'b0;
                out_nar_reg     <= 1'b1;
                out_timeout_reg <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.cfg_err       = cfg_err_reg;
    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = out_valid_reg;
    assign bus.out_sign      = out_sign_reg;
    assign bus.out_exp       = out_exp_reg;
    assign bus.out_man       = out_man_reg;
    assign bus.out_zero      = out_zero_reg;
    assign bus.out_nar       = out_nar_reg;
    assign bus.out_timeout   = out_timeout_reg;
    assign bus.mul_act       = act_reg;
    assign bus.mul_w         = mul_w_c;
    assign bus.mul_valid     = mul_valid_c;
    assign bus.mul_set       = mul_set_c;
    assign bus.mul_precision = prec_reg;

endmodule

// File: tb/tb_posit_mul_seq.sv
// Randomized self-checking bench for posit_mul_seq with a stubbed multiplier
// and a cycle-level reference model of handshake, serialization and capture.
module tb_posit_mul_seq;
    import posit_mac_pkg::*;

    localparam int ACT_WIDTH = 16;
    localparam int EXP_WIDTH = 5;
    localparam int MAN_WIDTH = 10;
    localparam int W_MAX     = 8;
    localparam int PREC_RST  = 4;
    localparam int TIMEOUT   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   model_prec = PREC_RST;

    always #5 clk = ~clk;

    posit_mul_seq_if #(.ACT_WIDTH(ACT_WIDTH), .EXP_WIDTH(EXP_WIDTH),
                       .MAN_WIDTH(MAN_WIDTH), .W_MAX(W_MAX)) bus ();

    posit_mul_seq #(.ACT_WIDTH(ACT_WIDTH), .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH),
                    .W_MAX(W_MAX), .PREC_RST(PREC_RST), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: the bits the multiplier must see, MSB first, are the low p bits of w.
    function automatic logic [7:0] ref_bits(input logic [7:0] w, input int p);
        logic [7:0] mask;
        mask = 8'((9'd1 << p) - 9'd1);
        return w & mask;
    endfunction

    function automatic logic ref_legal(input int p);
        return (p >= 2) && (p <= W_MAX);
    endfunction

    function automatic logic [22:0] got_result();
        return {bus.out_sign, bus.out_exp, bus.out_man, bus.out_zero, bus.out_nar, bus.out_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet_inputs();
        bus.cfg_valid = 1'b0; bus.cfg_precision = '0;
        bus.in_valid = 1'b0; bus.in_act = '0; bus.in_w = '0; bus.out_ready = 1'b1;
        bus.mul_sign = 1'b0; bus.mul_exp = '0; bus.mul_man = '0;
        bus.mul_zero = 1'b0; bus.mul_nar = 1'b0; bus.mul_done = 1'b0;
    endtask

    task automatic configure(input int p);
        bus.cfg_valid = 1'b1; bus.cfg_precision = 4'(p);
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        if (ref_legal(p)) model_prec = p;
    endtask

    task automatic send_op(input logic [15:0] act, input logic [7:0] w, output bit ok);
        bus.in_valid = 1'b1; bus.in_act = act; bus.in_w = w; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic observe_shift(input int p, output logic [7:0] bits, output int vcount,
                                 output logic [15:0] act_seen);
        bits = '0; vcount = 0; act_seen = bus.mul_act;
        for (int i = 0; i < p; i++) begin
            if (bus.mul_valid) begin
                vcount++;
                bits = {bits[6:0], bus.mul_w};
            end
            tick();
        end
    endtask

    task automatic drive_done(input int lat, input logic s, input logic [4:0] e,
                              input logic [13:0] m, input logic z, input logic n);
        for (int i = 1; i < lat; i++) tick();
        bus.mul_done = 1'b1; bus.mul_sign = s; bus.mul_exp = e; bus.mul_man = m;
        bus.mul_zero = z; bus.mul_nar = n;
        tick();
        bus.mul_done = 1'b0; bus.mul_zero = 1'b0; bus.mul_nar = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_prec = PREC_RST;
        vectors++;
        if ({bus.out_valid, bus.mul_valid, bus.mul_set, bus.cfg_err, bus.mul_w} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.out_valid, bus.mul_valid, bus.mul_set, bus.cfg_err, bus.mul_w});
        end
        vectors++;
        if (bus.mul_precision !== 4'(PREC_RST)) begin
            miscompares++; $display("FAIL reset_prec got=%0d exp=%0d", bus.mul_precision, PREC_RST);
        end
        vectors++;
        if (got_result() !== 23'd0 || bus.mul_act !== 16'd0) begin
            miscompares++; $display("FAIL reset_data got=%h/%h exp=0/0", got_result(), bus.mul_act);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_serialize();
        bit ok; logic [7:0] bits; int vc; logic [15:0] a; logic [22:0] held;
        bus.cfg_valid = 1'b1; bus.cfg_precision = 4'd4;
        tick();
        bus.cfg_valid = 1'b0;
        vectors++;
        if (bus.mul_set !== 1'b1) begin miscompares++; $display("FAIL cfg_set_pulse got=%b exp=1", bus.mul_set); end
        tick();
        vectors++;
        if ({bus.mul_set, bus.in_ready} !== 2'b01 || bus.mul_precision !== 4'd4) begin
            miscompares++; $display("FAIL cfg_after got set/ready=%b prec=%0d exp 01/4", {bus.mul_set, bus.in_ready}, bus.mul_precision);
        end
        model_prec = 4;
        send_op(16'h1234, 8'b0000_1010, ok);
        observe_shift(4, bits, vc, a);
        vectors++;
        if (!ok || bits !== 8'b1010 || vc !== 4 || a !== 16'h1234) begin
            miscompares++; $display("FAIL shift_1010 got ok=%0d bits=%b vcount=%0d act=%h exp 1/00001010/4/1234", ok, bits, vc, a);
        end
        vectors++;
        if (bus.mul_valid !== 1'b0 || bus.mul_act !== 16'h1234) begin
            miscompares++; $display("FAIL wait_hold got valid=%b act=%h exp 0/1234", bus.mul_valid, bus.mul_act);
        end
        bus.out_ready = 1'b0;
        drive_done(3, 1'b0, 5'b00011, 14'b01001010011100, 1'b0, 1'b0);
        held = {1'b0, 5'b00011, 14'b01001010011100, 3'b000};
        vectors++;
        if (bus.out_valid !== 1'b1 || got_result() !== held) begin
            miscompares++; $display("FAIL capture got valid=%b res=%h exp 1/%h", bus.out_valid, got_result(), held);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || got_result() !== held || bus.in_ready !== 1'b0 || bus.mul_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_%0d got valid=%b res=%h ready=%b exp 1/%h/0", i, bus.out_valid, got_result(), bus.in_ready, held);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL out_clear got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_cfg_err();
        int p;
        logic leg;
        for (int k = 0; k < 10; k++) begin
            p = (k == 0) ? 9 : int'($urandom_range(0, 15));
            leg = ref_legal(p);
            bus.cfg_valid = 1'b1; bus.cfg_precision = 4'(p);
            tick();
            bus.cfg_valid = 1'b0;
            vectors++;
            if (bus.cfg_err !== !leg || bus.mul_set !== leg) begin
                miscompares++; $display("FAIL cfg_%0d got err/set=%b%b exp=%b%b", p, bus.cfg_err, bus.mul_set, !leg, leg);
            end
            if (leg) model_prec = p;
            tick();
            vectors++;
            if (bus.mul_precision !== 4'(model_prec) || bus.cfg_err !== 1'b0) begin
                miscompares++; $display("FAIL cfg_prec_%0d got prec=%0d err=%b exp %0d/0", p, bus.mul_precision, bus.cfg_err, model_prec);
            end
        end
        configure(4);
    endtask

    task automatic test_cfg_priority();
        logic [7:0] w; logic [15:0] act; logic [7:0] bits; int vc; int n; logic [15:0] a;
        w = 8'($urandom); act = 16'($urandom);
        bus.cfg_valid = 1'b1; bus.cfg_precision = 4'd5;
        bus.in_valid = 1'b1; bus.in_act = act; bus.in_w = w;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL prio_ready got=%b exp=0", bus.in_ready); end
        tick();
        bus.cfg_valid = 1'b0;
        vectors++;
        if (bus.mul_set !== 1'b1) begin miscompares++; $display("FAIL prio_set got=%b exp=1", bus.mul_set); end
        n = 0;
        while (!bus.mul_valid && n < 10) begin tick(); n++; end
        bus.in_valid = 1'b0;
        model_prec = 5;
        vectors++;
        if (n !== 2) begin miscompares++; $display("FAIL prio_accept_delay got=%0d exp=2", n); end
        observe_shift(5, bits, vc, a);
        vectors++;
        if (bits !== ref_bits(w, 5) || vc !== 5 || a !== act || bus.mul_precision !== 4'd5) begin
            miscompares++; $display("FAIL prio_shift got bits=%b vc=%0d act=%h exp %b/5/%h", bits, vc, a, ref_bits(w, 5), act);
        end
        drive_done(1, 1'b1, 5'd7, 14'h1abc, 1'b0, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || got_result() !== {1'b1, 5'd7, 14'h1abc, 3'b000}) begin
            miscompares++; $display("FAIL prio_result got=%h", got_result());
        end
        tick();
    endtask

    task automatic test_timeout();
        bit ok; logic [7:0] bits; int vc; int n; logic [15:0] a;
        send_op(16'($urandom), 8'($urandom), ok);
        observe_shift(model_prec, bits, vc, a);
        n = 0;
        while (!bus.out_valid && n < 100) begin tick(); n++; end
        vectors++;
        if (n !== TIMEOUT) begin miscompares++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TIMEOUT); end
        vectors++;
        if (got_result() !== {1'b0, 5'd0, 14'd0, 3'b011}) begin
            miscompares++; $display("FAIL timeout_fields got=%h exp=%h", got_result(), {1'b0, 5'd0, 14'd0, 3'b011});
        end
        tick();
    endtask

    task automatic test_zero();
        bit ok; logic [7:0] bits; int vc; logic [15:0] a; logic [4:0] e; logic [13:0] m;
        e = 5'($urandom); m = 14'($urandom);
        send_op(16'h0000, 8'($urandom), ok);
        observe_shift(model_prec, bits, vc, a);
        drive_done(2, 1'b1, e, m, 1'b1, 1'b0);
        vectors++;
        if (bus.out_zero !== 1'b1 || got_result() !== {1'b1, e, m, 3'b100}) begin
            miscompares++; $display("FAIL zero_flag got=%h exp=%h", got_result(), {1'b1, e, m, 3'b100});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok; logic [7:0] w; logic [15:0] act; logic [7:0] bits; int vc; logic [15:0] a;
        int lat; int acc; int prev_acc; int span; logic s, z, nr; logic [4:0] e; logic [13:0] m;
        configure(int'($urandom_range(2, W_MAX)));
        prev_acc = 0; span = 0;
        for (int k = 0; k < 16; k++) begin
            w = 8'($urandom); act = 16'($urandom); lat = int'($urandom_range(1, 6));
            s = 1'($urandom); z = 1'($urandom); nr = 1'($urandom); e = 5'($urandom); m = 14'($urandom);
            send_op(act, w, ok);
            acc = cyc;
            vectors++;
            if (!ok || (k > 0 && acc - prev_acc !== span)) begin
                miscompares++; $display("FAIL b2b_rate_%0d got ok=%0d spacing=%0d exp 1/%0d", k, ok, acc - prev_acc, span);
            end
            observe_shift(model_prec, bits, vc, a);
            vectors++;
            if (bits !== ref_bits(w, model_prec) || vc !== model_prec || a !== act) begin
                miscompares++; $display("FAIL b2b_shift_%0d got bits=%b vc=%0d act=%h exp %b/%0d/%h", k, bits, vc, a, ref_bits(w, model_prec), model_prec, act);
            end
            drive_done(lat, s, e, m, z, nr);
            vectors++;
            if (bus.out_valid !== 1'b1 || got_result() !== {s, e, m, z, nr, 1'b0}) begin
                miscompares++; $display("FAIL b2b_result_%0d got valid=%b res=%h exp 1/%h", k, bus.out_valid, got_result(), {s, e, m, z, nr, 1'b0});
            end
            prev_acc = acc;
            span = model_prec + lat + 1;
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        bit ok; logic [7:0] w; logic [7:0] bits; int vc; logic [15:0] a;
        configure(6);
        send_op(16'hbeef, 8'($urandom), ok);
        tick();
        vectors++;
        if (bus.mul_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_shift got=%b exp=1", bus.mul_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_prec = PREC_RST;
        vectors++;
        if ({bus.mul_valid, bus.out_valid, bus.mul_set, bus.in_ready} !== 4'b0001 || bus.mul_precision !== 4'(PREC_RST)) begin
            miscompares++; $display("FAIL rst_mid_shift got v/ov/set/rdy=%b prec=%0d exp 0001/%0d", {bus.mul_valid, bus.out_valid, bus.mul_set, bus.in_ready}, bus.mul_precision, PREC_RST);
        end
        w = 8'($urandom);
        send_op(16'h5a5a, w, ok);
        observe_shift(PREC_RST, bits, vc, a);
        vectors++;
        if (bits !== ref_bits(w, PREC_RST) || vc !== PREC_RST || bus.mul_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_after_op got bits=%b vc=%0d exp %b/%0d", bits, vc, ref_bits(w, PREC_RST), PREC_RST);
        end
        bus.out_ready = 1'b0;
        drive_done(1, 1'b0, 5'd1, 14'd1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_discard got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_serialize();
        test_cfg_err();
        test_cfg_priority();
        test_timeout();
        test_zero();
        test_back_to_back();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
